// File: rtl/intc_multi.sv
// ============================================================================
// intc_multi -- multi-channel interrupt controller
//
// Collects N interrupt sources into a write-1-to-clear STATUS register. Each
// channel can be masked and set to rising-edge or level trigger. The lowest
// active channel index is presented as a registered vector together with a
// registered request line.
//
// Register map (addr):
//   0 STATUS  pending bits, write-1-to-clear
//   1 MASK    per-channel enable, read/write
//   2 MODE    per-channel trigger mode (0 rising edge, 1 level), read/write
//   3 CTRL    bit0 GEN (global enable), bit1 ACLR (auto-clear on ack)
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   ce        register access strobe
//   wren      write qualifier (write when ce & wren)
//   addr      register select
//   from_cpu  write data
//   to_cpu    registered read data (pre-update value, 1 cycle latency)
//   irq_in    interrupt sources, bit i = channel i
//   int_ack   single-cycle acknowledge of the presented vector
//   int_rq    registered interrupt request
//   int_addr  registered vector of the highest-priority active channel
//
// Build option:
//   INTC_MULTI_SYNC_EN  when defined, irq_in passes through a 2-flop
//                       synchronizer (reset to all ones) before sampling.
// ============================================================================
module intc_multi #(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          wren,
  input  logic [1:0]    addr,
  input  logic [N-1:0]  from_cpu,
  output logic [N-1:0]  to_cpu,
  input  logic [N-1:0]  irq_in,
  input  logic          int_ack,
  output logic          int_rq,
  output logic [AW-1:0] int_addr
);

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_MODE   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // Lowest set index of vec; channel 0 has the highest priority.
  function automatic logic [AW-1:0] lowest_index(input logic [N-1:0] vec);
    logic [AW-1:0] idx;
    idx = {AW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = AW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [N-1:0]  status_r;
  logic [N-1:0]  mask_r;
  logic [N-1:0]  mode_r;
  logic [1:0]    ctrl_r;
  logic [N-1:0]  prev_r;
  logic [N-1:0]  to_cpu_r;
  logic          int_rq_r;
  logic [AW-1:0] int_addr_r;

  logic [N-1:0]  sampled_s;
  logic          gen_s;
  logic          aclr_s;
  logic          wr_s;
  logic [N-1:0]  trig_s;
  logic [N-1:0]  w1c_clr_s;
  logic [N-1:0]  ack_clr_s;
  logic [N-1:0]  status_nxt_s;
  logic [N-1:0]  active_s;
  logic [N-1:0]  rdata_s;

`ifdef INTC_MULTI_SYNC_EN
  logic [N-1:0] sync1_r;
  logic [N-1:0] sync2_r;

  // Two-flop input synchronizer; all-ones reset so sources high at reset
  // exit do not look like fresh edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= {N{1'b1}};
      sync2_r <= {N{1'b1}};
    end else begin
      sync1_r <= irq_in;
      sync2_r <= sync1_r;
    end
  end

  assign sampled_s = sync2_r;
`else
  assign sampled_s = irq_in;
`endif

  assign gen_s    = ctrl_r[0];
  assign aclr_s   = ctrl_r[1];
  assign wr_s     = ce & wren;
  assign active_s = status_r & mask_r & {N{gen_s}};

  // Trigger detection and STATUS next-state: clears first, triggers win.
  always_comb begin
    trig_s    = (sampled_s & ~prev_r & ~mode_r & {N{gen_s}}) |
                (sampled_s & mode_r & {N{gen_s}});
    w1c_clr_s = {N{1'b0}};
    ack_clr_s = {N{1'b0}};
    if (wr_s && (addr == ADDR_STATUS)) begin
      w1c_clr_s = from_cpu;
    end else begin
      w1c_clr_s = {N{1'b0}};
    end
    for (int i = 0; i < N; i++) begin
      if (int_ack && aclr_s && (int_addr_r == AW'(i))) begin
        ack_clr_s[i] = 1'b1;
      end else begin
        ack_clr_s[i] = 1'b0;
      end
    end
    status_nxt_s = (status_r & ~(w1c_clr_s | ack_clr_s)) | trig_s;
  end

  // Read mux over the current (pre-update) register contents.
  always_comb begin
    rdata_s = {N{1'b0}};
    case (addr)
      ADDR_STATUS: rdata_s = status_r;
      ADDR_MASK:   rdata_s = mask_r;
      ADDR_MODE:   rdata_s = mode_r;
      ADDR_CTRL:   rdata_s = {{(N-2){1'b0}}, ctrl_r};
      default:     rdata_s = {N{1'b0}};
    endcase
  end

  // Register file, edge history and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_r <= {N{1'b0}};
      mask_r   <= {N{1'b0}};
      mode_r   <= {N{1'b0}};
      ctrl_r   <= 2'b00;
      prev_r   <= {N{1'b1}};
      to_cpu_r <= {N{1'b0}};
    end else begin
      status_r <= status_nxt_s;
      prev_r   <= sampled_s;
      if (wr_s && (addr == ADDR_MASK)) begin
        mask_r <= from_cpu;
      end else begin
        mask_r <= mask_r;
      end
      if (wr_s && (addr == ADDR_MODE)) begin
        mode_r <= from_cpu;
      end else begin
        mode_r <= mode_r;
      end
      if (wr_s && (addr == ADDR_CTRL)) begin
        ctrl_r <= from_cpu[1:0];
      end else begin
        ctrl_r <= ctrl_r;
      end
      if (ce) begin
        to_cpu_r <= rdata_s;
      end else begin
        to_cpu_r <= to_cpu_r;
      end
    end
  end

  // Request and vector follow the registered STATUS one cycle later; the
  // vector holds its last value while nothing is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_rq_r   <= 1'b0;
      int_addr_r <= {AW{1'b0}};
    end else begin
      int_rq_r <= |active_s;
      if (|active_s) begin
        int_addr_r <= lowest_index(active_s);
      end else begin
        int_addr_r <= int_addr_r;
      end
    end
  end

  assign to_cpu   = to_cpu_r;
  assign int_rq   = int_rq_r;
  assign int_addr = int_addr_r;

endmodule

// File: tb/tb_intc_multi.sv
// Directed bench for intc_multi (N=8, no input synchronizer).
module tb_intc_multi;

  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          ce;
  logic          wren;
  logic [1:0]    addr;
  logic [N-1:0]  from_cpu;
  logic [N-1:0]  to_cpu;
  logic [N-1:0]  irq_in;
  logic          int_ack;
  logic          int_rq;
  logic [AW-1:0] int_addr;

  int checks;
  int failures;
  logic [N-1:0] rd;
  logic [N-1:0] held;

  intc_multi #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .wren     (wren),
    .addr     (addr),
    .from_cpu (from_cpu),
    .to_cpu   (to_cpu),
    .irq_in   (irq_in),
    .int_ack  (int_ack),
    .int_rq   (int_rq),
    .int_addr (int_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [N-1:0] d);
    ce = 1'b1; wren = 1'b1; addr = a; from_cpu = d;
    tick();
    ce = 1'b0; wren = 1'b0; from_cpu = 8'h00;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [N-1:0] d);
    ce = 1'b1; wren = 1'b0; addr = a;
    tick();
    d = to_cpu;
    ce = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; ce = 1'b0; wren = 1'b0; addr = 2'd0;
    from_cpu = 8'h00; irq_in = 8'h00; int_ack = 1'b0;
    tick(); tick();
    check("reset_to_cpu", {24'h0, to_cpu}, 32'h0);
    check("reset_int_rq", {31'h0, int_rq}, 32'h0);
    check("reset_int_addr", {29'h0, int_addr}, 32'h0);
    rst = 1'b0;
    tick();
    read_reg(2'd0, rd); check("reset_status", {24'h0, rd}, 32'h0);
    read_reg(2'd1, rd); check("reset_mask", {24'h0, rd}, 32'h0);

    // Edge capture on channel 5
    write_reg(2'd1, 8'hFF);
    write_reg(2'd3, 8'hFF);
    read_reg(2'd3, rd); check("ctrl_readback", {24'h0, rd}, 32'h3);
    write_reg(2'd3, 8'h01);
    irq_in = 8'h20; tick(); irq_in = 8'h00;
    check("edge_rq_1cyc", {31'h0, int_rq}, 32'h0);
    tick();
    check("edge_rq_2cyc", {31'h0, int_rq}, 32'h1);
    check("edge_addr", {29'h0, int_addr}, 32'h5);
    read_reg(2'd0, rd); check("edge_status", {24'h0, rd}, 32'h20);
    held = rd;
    tick(); tick();
    check("to_cpu_hold", {24'h0, to_cpu}, {24'h0, held});

    // Priority between channels 6 and 2
    write_reg(2'd0, 8'h20);
    irq_in = 8'h44; tick(); irq_in = 8'h00;
    tick();
    check("prio_addr", {29'h0, int_addr}, 32'h2);
    check("prio_rq", {31'h0, int_rq}, 32'h1);
    write_reg(2'd0, 8'h04);
    check("prio_rq_during", {31'h0, int_rq}, 32'h1);
    tick();
    check("prio_addr_next", {29'h0, int_addr}, 32'h6);
    check("prio_rq_next", {31'h0, int_rq}, 32'h1);
    read_reg(2'd0, rd); check("prio_status", {24'h0, rd}, 32'h40);
    write_reg(2'd0, 8'hFF);

    // Level mode with auto-clear on ack
    write_reg(2'd2, 8'h01);
    write_reg(2'd3, 8'h03);
    read_reg(2'd2, rd); check("mode_readback", {24'h0, rd}, 32'h1);
    irq_in = 8'h01; tick(); tick();
    check("level_rq", {31'h0, int_rq}, 32'h1);
    check("level_addr", {29'h0, int_addr}, 32'h0);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    read_reg(2'd0, rd); check("level_ack_held", {24'h0, rd}, 32'h1);
    irq_in = 8'h00; tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tick();
    check("level_rq_clear", {31'h0, int_rq}, 32'h0);
    read_reg(2'd0, rd); check("level_status_clear", {24'h0, rd}, 32'h0);
    write_reg(2'd2, 8'h00);
    write_reg(2'd3, 8'h01);

    // Trigger wins over same-cycle W1C on channel 3
    irq_in = 8'h08;
    write_reg(2'd0, 8'h08);
    irq_in = 8'h00;
    read_reg(2'd0, rd); check("collision_status", {24'h0, rd}, 32'h08);

    // Concurrent W1C (ch3) and ack clear (ch1)
    irq_in = 8'h02; tick(); irq_in = 8'h00;
    tick();
    check("concur_addr", {29'h0, int_addr}, 32'h1);
    write_reg(2'd3, 8'h03);
    int_ack = 1'b1;
    write_reg(2'd0, 8'h08);
    int_ack = 1'b0;
    read_reg(2'd0, rd); check("concur_status", {24'h0, rd}, 32'h0);
    write_reg(2'd3, 8'h01);

    // Masking and global enable
    irq_in = 8'h10; tick(); irq_in = 8'h00;
    write_reg(2'd1, 8'hEF);
    tick();
    check("mask_rq", {31'h0, int_rq}, 32'h0);
    write_reg(2'd1, 8'hFF);
    write_reg(2'd3, 8'h00);
    tick();
    check("gen_off_rq", {31'h0, int_rq}, 32'h0);
    irq_in = 8'h01; tick(); irq_in = 8'h00;
    read_reg(2'd0, rd); check("gen_off_status", {24'h0, rd}, 32'h10);

    // Reset with all inputs high, then a fresh edge on channel 7
    irq_in = 8'hFF;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("rst2_int_rq", {31'h0, int_rq}, 32'h0);
    check("rst2_int_addr", {29'h0, int_addr}, 32'h0);
    write_reg(2'd1, 8'hFF);
    write_reg(2'd3, 8'h01);
    tick();
    read_reg(2'd0, rd); check("rst2_no_capture", {24'h0, rd}, 32'h0);
    irq_in = 8'h7F; tick();
    irq_in = 8'hFF; tick();
    read_reg(2'd0, rd); check("rst2_ch7_status", {24'h0, rd}, 32'h80);
    check("rst2_ch7_rq", {31'h0, int_rq}, 32'h1);
    check("rst2_ch7_addr", {29'h0, int_addr}, 32'h7);

    // Ack without ACLR leaves STATUS alone
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    read_reg(2'd0, rd); check("noaclr_status", {24'h0, rd}, 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intc_multi.md
INTC_MULTI -- requirements
Module: intc_multi

Interface
REQ-001 Parameter N, default 8, number of interrupt channels; legal range 2..32.
REQ-002 Parameter AW, default $clog2(N), vector address width; derived and not overridden.
REQ-003 Reset rst, synchronous, active-high; clock clk.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 ce  input  1  register access strobe.
REQ-007 wren  input  1  write qualifier; a write occurs when ce & wren.
REQ-008 addr  input  2  register select: 0 STATUS, 1 MASK, 2 MODE, 3 CTRL.
REQ-009 from_cpu  input  N  write data.
REQ-010 to_cpu  output  N  registered read data.
REQ-011 irq_in  input  N  interrupt sources; bit i is channel i.
REQ-012 int_ack  input  1  single-cycle acknowledge of the currently presented vector.
REQ-013 int_rq  output  1  registered interrupt request.
REQ-014 int_addr  output  AW  registered vector of the highest-priority pending channel.

Function
REQ-015 The STATUS register holds N pending bits; a write clears each bit written as 1 (write-1-to-clear) and leaves bits written as 0 unchanged.
REQ-016 The MASK register holds N per-channel enables and is plain read/write.
REQ-017 The MODE register holds N bits, where 0 selects rising-edge mode and 1 selects level mode for channel i; it is plain read/write.
REQ-018 The CTRL register uses bit0 as the global enable (GEN), bit1 as auto-clear-on-ack (ACLR), and reads other bits as 0.
REQ-019 The block registers prev_in from the sampled input every cycle, regardless of GEN.
REQ-020 Edge trigger is sampled & ~prev_in & ~MODE & {N{GEN}}.
REQ-021 Level trigger is sampled & MODE & {N{GEN}}, and is asserted every cycle the input is high.
REQ-022 When ACLR=1, int_ack clears STATUS[int_addr]; when ACLR=0, int_ack has no effect.
REQ-023 A trigger on a channel wins over a same-cycle W1C write or ack clear on that channel, so the bit ends the cycle set.
REQ-024 Concurrent W1C and ack clears on different channels both take effect.
REQ-025 A read (ce & ~wren, or ce & wren) loads to_cpu with the pre-update register value; latency is 1 cycle, and to_cpu holds its value when ce=0.
REQ-026 The active set is STATUS & MASK & {N{GEN}}.
REQ-027 int_rq, registered, equals |active; it is asserted 1 cycle after STATUS updates, i.e. 2 cycles after an input edge with no synchronizer.
REQ-028 int_addr, registered, is the lowest set index of active (channel 0 has highest priority); it holds its previous value when active=0.
REQ-029 When GEN goes to 0, STATUS is retained, new triggers are blocked, and int_rq deasserts on the next cycle.
REQ-030 An edge already high when GEN rises is not captured, because prev_in is already high.

Reset
REQ-031 While rst is asserted, STATUS, MASK, MODE, CTRL, to_cpu, int_addr and int_rq are cleared to 0.
REQ-032 While rst is asserted, prev_in is set to all ones, so inputs that are high at reset exit produce no edge.
REQ-033 A reset asserted mid-operation discards all pending interrupts and any access in flight, and takes priority over writes, triggers and acks in the same cycle.

Configuration
REQ-034 The macro INTC_MULTI_SYNC_EN controls input synchronization.
REQ-035 When INTC_MULTI_SYNC_EN is defined, irq_in passes through a 2-flop synchronizer, reset to all ones, before sampling, which adds 2 cycles to trigger latency.
REQ-036 When INTC_MULTI_SYNC_EN is not defined, sampled = irq_in directly.

Verification (N=8, no sync)
REQ-037 Edge capture: MASK=0xFF, CTRL=0x01, pulse irq_in[5] -> STATUS=0x20; int_rq=1 and int_addr=5, 2 cycles after the pulse.
REQ-038 Priority: edges on channels 6 and 2 in the same cycle -> int_addr=2; write STATUS=0x04 -> int_addr=6, int_rq stays 1.
REQ-039 Level with ACLR: MODE=0x01, CTRL=0x03, irq_in[0] held high, int_ack pulsed -> STATUS[0] stays 1; drop irq_in[0] and ack -> STATUS=0x00 and int_rq=0 one cycle later.
REQ-040 Collision: W1C of bit 3 in the same cycle as a new edge on channel 3 -> STATUS[3]=1.
REQ-041 Masking/GEN: STATUS=0x10 with MASK=0xEF -> int_rq=0; set CTRL=0x00 with MASK=0xFF -> int_rq=0 and STATUS still reads 0x10.
REQ-042 Reset: irq_in=0xFF held through rst and GEN then enabled -> no capture; then a 1->0->1 transition on channel 7 -> STATUS=0x80.
